// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one spi_master between two frame requesters.
// Round-robin on contention, setup/gap spacing around m_spi_en,
// illegal-mode rejection and a per-frame timeout on m_spi_done.
module spi_arbiter #(
    parameter int SETUP_CYC   = 4,
    parameter int GAP_CYC     = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [1:0]  req0_mode,
    input  logic [15:0] req0_sdata,
    output logic        req0_ready,
    output logic [15:0] req0_rdata,
    output logic        req0_done,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic [1:0]  req1_mode,
    input  logic [15:0] req1_sdata,
    output logic        req1_ready,
    output logic [15:0] req1_rdata,
    output logic        req1_done,
    output logic        req1_err,
    output logic        m_spi_en,
    output logic [1:0]  m_spi_mode,
    output logic [15:0] m_spi_sdata,
    input  logic [15:0] m_spi_rdata,
    input  logic        m_spi_done,
    output logic        busy,
    output logic        grant_id
);

    localparam logic [3:0]  SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0]  GAP_LAST   = 4'(GAP_CYC - 1);
    localparam logic [12:0] TMO_LAST   = 13'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        SETUP = 4'b0010,
        BUSY  = 4'b0100,
        GAP   = 4'b1000
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [12:0]       tcnt_reg, tcnt_next;
    logic              rr_reg, rr_next;
    logic              gid_reg, gid_next;
    logic              err_pend_reg, err_pend_next;
    logic [1:0]        mode_reg, mode_next;
    logic [15:0]       sdata_reg, sdata_next;
    logic [1:0]        ready_reg, ready_next;
    logic [1:0]        done_reg, done_next;
    logic [1:0]        err_reg, err_next;
    logic [1:0][15:0]  rdata_reg, rdata_next;

    logic              pick;
    logic [1:0]        sel_mode;
    logic [15:0]       sel_sdata;

    // FSM state register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, counters, latched frame and requester pulses
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        tcnt_next     = tcnt_reg;
        rr_next       = rr_reg;
        gid_next      = gid_reg;
        err_pend_next = 1'b0;
        mode_next     = mode_reg;
        sdata_next    = sdata_reg;
        ready_next    = 2'b00;
        done_next     = 2'b00;
        err_next      = 2'b00;
        rdata_next    = rdata_reg;
        pick          = 1'b0;
        sel_mode      = req0_mode;
        sel_sdata     = req0_sdata;

        case (state_reg)
            IDLE: begin
                if (err_pend_reg) begin
                    // Rejected frame: report it and skip granting this cycle,
                    // which also covers the requester still holding valid.
                    done_next[gid_reg] = 1'b1;
                    err_next[gid_reg]  = 1'b1;
                end else if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) begin
                        pick    = rr_reg;
                        rr_next = ~rr_reg;
                    end else begin
                        pick = req1_valid;
                    end
                    sel_mode         = pick ? req1_mode : req0_mode;
                    sel_sdata        = pick ? req1_sdata : req0_sdata;
                    ready_next[pick] = 1'b1;
                    gid_next         = pick;
                    mode_next        = sel_mode;
                    sdata_next       = sel_sdata;
                    // Only modes 1 and 3 are legal (bit 0 set)
                    if (sel_mode[0]) begin
                        state_next = SETUP;
                        cnt_next   = 4'd0;
                    end else begin
                        err_pend_next = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt_reg == SETUP_LAST) begin
                    state_next = BUSY;
                    tcnt_next  = 13'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            BUSY: begin
                // A done arriving on the timeout cycle still counts as success
                if (m_spi_done) begin
                    rdata_next[gid_reg] = m_spi_rdata;
                    done_next[gid_reg]  = 1'b1;
                    state_next          = GAP;
                    cnt_next            = 4'd0;
                end else if (tcnt_reg == TMO_LAST) begin
                    done_next[gid_reg] = 1'b1;
                    err_next[gid_reg]  = 1'b1;
                    state_next         = GAP;
                    cnt_next           = 4'd0;
                end else begin
                    tcnt_next = tcnt_reg + 13'd1;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers, all cleared asynchronously
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= 4'd0;
            tcnt_reg     <= 13'd0;
            rr_reg       <= 1'b0;
            gid_reg      <= 1'b0;
            err_pend_reg <= 1'b0;
            mode_reg     <= 2'd1;
            sdata_reg    <= 16'd0;
            ready_reg    <= 2'b00;
            done_reg     <= 2'b00;
            err_reg      <= 2'b00;
            rdata_reg    <= '0;
        end else begin
            cnt_reg      <= cnt_next;
            tcnt_reg     <= tcnt_next;
            rr_reg       <= rr_next;
            gid_reg      <= gid_next;
            err_pend_reg <= err_pend_next;
            mode_reg     <= mode_next;
            sdata_reg    <= sdata_next;
            ready_reg    <= ready_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            rdata_reg    <= rdata_next;
        end
    end

    assign m_spi_en    = (state_reg == BUSY);
    assign m_spi_mode  = mode_reg;
    assign m_spi_sdata = sdata_reg;
    assign busy        = (state_reg != IDLE);
    assign grant_id    = gid_reg;

    assign req0_ready = ready_reg[0];
    assign req0_done  = done_reg[0];
    assign req0_err   = err_reg[0];
    assign req0_rdata = rdata_reg[0];
    assign req1_ready = ready_reg[1];
    assign req1_done  = done_reg[1];
    assign req1_err   = err_reg[1];
    assign req1_rdata = rdata_reg[1];

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares one spi_master instance between two independent requesters (e.g. ADC-config path and DAC-update path).
- Accepts one 16-bit frame request at a time and arbitrates round-robin.
- Sequences spi_en, spi_mode and spi_sdata into the master, then returns spi_rdata and a completion pulse to the winning requester.
- Adds a per-frame timeout so a stuck master cannot hang either requester.

Parameters:
- SETUP_CYC, 4: sys_clk cycles that mode/sdata are held stable with m_spi_en low before enable is raised.
- GAP_CYC, 8: sys_clk cycles m_spi_en is held low after a frame, before the next grant.
- TIMEOUT_CYC, 4096: max sys_clk cycles in BUSY waiting for m_spi_done; 13-bit counter.

Ports:
- sys_clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 frame request; level, held until req0_ready
- req0_mode  in  2  requester 0 SPI mode; legal values 1 and 3
- req0_sdata  in  16  requester 0 transmit word
- req0_ready  out  1  one-cycle pulse: request accepted, inputs sampled
- req0_rdata  out  16  requester 0 last received word
- req0_done  out  1  one-cycle pulse: requester 0 frame finished
- req0_err  out  1  valid with req0_done: 1 = timeout or illegal mode
- req1_valid / req1_mode / req1_sdata / req1_ready / req1_rdata / req1_done / req1_err: same as requester 0, for requester 1
- m_spi_en  out  1  to master spi_en
- m_spi_mode  out  2  to master spi_mode
- m_spi_sdata  out  16  to master spi_sdata
- m_spi_rdata  in  16  from master spi_rdata
- m_spi_done  in  1  from master spi_done pulse
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  index of current or last granted requester

Behaviour:
- Clock and reset: one clock, sys_clk; reset is asynchronous and active-low, rst_n. All flops are async-cleared.
- Reset values:
  - All outputs 0.
  - m_spi_mode = 2'd1.
  - Round-robin pointer rr = 0, meaning requester 0 has priority first.
- State machine, one-hot: IDLE, SETUP, BUSY, GAP.
- IDLE:
  - If exactly one valid is high, grant it.
  - If both are high, grant requester rr, then set rr to the other requester.
  - On grant: pulse reqN_ready for 1 cycle, latch mode and sdata into m_spi_mode/m_spi_sdata, set grant_id, go to SETUP on the next cycle.
  - Grant-to-ready latency is 1 cycle after valid is seen in IDLE.
- Illegal mode (0 or 2):
  - Still accepted with a ready pulse.
  - Next cycle: reqN_done=1, reqN_err=1, reqN_rdata unchanged.
  - No SETUP and no m_spi_en; return to IDLE. rr is still updated.
- SETUP: m_spi_en=0; count SETUP_CYC cycles, then go to BUSY.
- BUSY:
  - m_spi_en=1, held level; m_spi_mode and m_spi_sdata stay frozen.
  - Timeout counter increments every cycle.
  - On m_spi_done=1: capture m_spi_rdata into reqN_rdata; pulse reqN_done=1, err=0 in the following cycle; drive m_spi_en=0; go to GAP.
  - If the counter reaches TIMEOUT_CYC-1 with no done: pulse reqN_done=1 and reqN_err=1, leave rdata unchanged, m_spi_en=0, go to GAP.
  - If done and timeout occur in the same cycle, done wins and err=0.
- GAP: m_spi_en=0 for GAP_CYC cycles, then IDLE. Requests arriving during SETUP, BUSY or GAP wait, with valid held.
- m_spi_done while not in BUSY is ignored.
- Requester inputs changing after the ready pulse are ignored, since the frame was latched.
- A requester raising valid again in the same cycle as its done pulse is handled normally in the next IDLE.
- reqN_rdata holds its value until the next successful frame for that requester.
- Reset mid-frame: all state is cleared immediately and m_spi_en drops to 0 asynchronously. The master is reset by the same rst_n.
- Counters: SETUP and GAP use a 4-bit counter; timeout uses a 13-bit counter. All counters clear on state entry.

Test Plan:
- req0 only, mode=1, sdata=16'hA55A; model master returns done 40 cycles after m_spi_en rises with rdata=16'h1234 -> ready0 at T+1, m_spi_en high after 4 SETUP cycles, req0_rdata=16'h1234, done0=1, err0=0, then 8 GAP cycles with en low.
- req0 and req1 asserted in the same cycle after reset -> req0 served first, then req1. Repeat with both asserted -> req1 served first (round-robin alternation verified over 4 frames).
- req1 mode=3, master model never asserts done -> done1=1, err1=1 exactly TIMEOUT_CYC cycles after entering BUSY, m_spi_en low, req1_rdata unchanged, arbiter returns to IDLE after GAP.
- req0 mode=2 -> ready0 then done0=1, err0=1 on the next cycle, m_spi_en never rises, busy returns low.
- rst_n pulsed low while in BUSY -> m_spi_en=0, busy=0, all done/ready outputs 0 immediately; after release, a new req0 frame completes normally.
- Spurious m_spi_done in IDLE and GAP -> no done pulse and no rdata change; the frame in progress still completes correctly.
